// File: rtl/r2r_conversion_controller.sv
// Sequences one 8-bit R2R-ladder conversion (SAR or linear ramp): drives the ladder code,
// waits a settle time per step, samples the synchronized comparator and builds the result.
module r2r_conversion_controller #(
  parameter int SETTLE_CYCLES = 6250,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       algorithm_sel,
  input  logic       continuous,
  input  logic       comp_r2r,
  output logic [7:0] R2R_out,
  output logic [7:0] result,
  output logic       valid,
  output logic       busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_s;
  logic                   alg;
  logic [2:0]             bit_idx;
  logic [CNT_W-1:0]       step_cnt;
  logic                   accept;
  logic                   step_end;
  logic                   sar_last;
  logic                   ramp_last;
  logic                   conv_last;
  logic [7:0]             sar_code;
  logic [7:0]             ramp_result;

  // The comparator is asynchronous to clk; only the last synchronizer stage is ever used.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= comp_r2r;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign comp_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    sar_code = R2R_out;
    if (!comp_s) begin
      sar_code[bit_idx] = 1'b0;
    end
    if (bit_idx != 3'd0) begin
      sar_code[bit_idx - 3'd1] = 1'b1;
    end
    sar_last    = (bit_idx == 3'd0);
    ramp_last   = !comp_s || (R2R_out == 8'hFF);
    // A ramp that stops on a low comparator reports the last code that was still below Vin.
    ramp_result = !comp_s ? ((R2R_out == 8'h00) ? 8'h00 : R2R_out - 8'd1) : 8'hFF;
    conv_last   = alg ? ramp_last : sar_last;
    step_end    = (state == SETTLE) && (step_cnt == CNT_LAST);
    accept      = ((state == IDLE) && start) || ((state == DONE) && continuous);

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (step_end && conv_last) state_nxt = DONE;
      DONE:    state_nxt = continuous ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == DONE);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      R2R_out  <= 8'h00;
      result   <= 8'h00;
      alg      <= 1'b0;
      bit_idx  <= 3'd0;
      step_cnt <= '0;
    end else if (accept) begin
      alg      <= algorithm_sel;
      R2R_out  <= algorithm_sel ? 8'h00 : 8'h80;
      bit_idx  <= 3'd7;
      step_cnt <= '0;
    end else if (state == SETTLE) begin
      if (step_end) begin
        step_cnt <= '0;
        if (alg) begin
          if (ramp_last) begin
            result <= ramp_result;
          end else begin
            R2R_out <= R2R_out + 8'd1;
          end
        end else begin
          R2R_out <= sar_code;
          if (sar_last) begin
            result <= sar_code;
          end else begin
            bit_idx <= bit_idx - 3'd1;
          end
        end
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule
